// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: bundles the button, time and load signals of the time-setting controller.
//   btn_mode/btn_inc/btn_dec : raw active-high push-buttons (to controller)
//   tick_1hz                 : one-clk 1 Hz strobe (to controller)
//   hour_in/min_in/sec_in    : current time (to controller)
//   data                     : value to load into a time counter (from controller)
//   load_hour/min/sec        : one-cycle load strobes (from controller)
//   run_en                   : counter enable (from controller)
//   edit_field               : 0=run, 1=hour, 2=minute, 3=second (from controller)
//   blink                    : blink phase for the edited field (from controller)
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic       tick_1hz;
    logic [4:0] hour_in;
    logic [5:0] min_in;
    logic [5:0] sec_in;
    logic [5:0] data;
    logic       load_hour;
    logic       load_min;
    logic       load_sec;
    logic       run_en;
    logic [1:0] edit_field;
    logic       blink;

    // Driver side: buttons and current time out, load/display signals in.
    modport master (
        output btn_mode, btn_inc, btn_dec, tick_1hz, hour_in, min_in, sec_in,
        input  data, load_hour, load_min, load_sec, run_en, edit_field, blink
    );

    // Controller side.
    modport slave (
        input  btn_mode, btn_inc, btn_dec, tick_1hz, hour_in, min_in, sec_in,
        output data, load_hour, load_min, load_sec, run_en, edit_field, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: three-button time-setting controller for an hour/minute/second clock.
// Buttons are synchronized and debounced into single-cycle press pulses; a mode press walks
// RUN -> hour -> minute -> second -> RUN, loading the edited value into the matching counter on
// each exit from an edit field. inc/dec adjust the edited value with wrap-around.
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : time_set_ctrl_if.slave (buttons, tick, current time in; data/loads/status out)
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input logic            i_clk,
    input logic            i_rst_n,
    time_set_ctrl_if.slave io_bus
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StEditHour = 2'd1,
        StEditMin  = 2'd2,
        StEditSec  = 2'd3
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Button conditioning: bit 0 = mode, bit 1 = inc, bit 2 = dec.
    // ---------------------------------------------------------------------------------------
    logic [2:0]      w_btn_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_level;
    logic [2:0]      r_level_dly;
    logic [2:0]      r_press;
    logic [CntW-1:0] r_cnt [3];

    assign w_btn_raw = {io_bus.btn_dec, io_bus.btn_inc, io_bus.btn_mode};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_level     <= '0;
            r_level_dly <= '0;
            r_press     <= '0;
            for (int k = 0; k < 3; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_sync1     <= w_btn_raw;
            r_sync2     <= r_sync1;
            r_level_dly <= r_level;
            // Rising edge of the debounced level gives exactly one pulse per press.
            r_press     <= r_level & ~r_level_dly;
            for (int k = 0; k < 3; k++) begin
                if (!r_sync2[k]) begin
                    r_cnt[k]   <= '0;
                    r_level[k] <= 1'b0;
                end else if (r_cnt[k] != CntMax) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                    // Level rises on the same edge the counter reaches its terminal count.
                    if (r_cnt[k] == CntMax - 1'b1) begin
                        r_level[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Edit FSM
    // ---------------------------------------------------------------------------------------
    state_e     r_state;
    state_e     w_state_next;
    logic [5:0] r_edit_val;
    logic [5:0] w_edit_val_next;
    logic [5:0] r_data;
    logic [5:0] w_data_next;
    logic       r_load_hour;
    logic       r_load_min;
    logic       r_load_sec;
    logic       w_load_hour_next;
    logic       w_load_min_next;
    logic       w_load_sec_next;
    logic       r_blink;
    logic       w_blink_next;

    logic       w_mode;
    logic       w_inc;
    logic       w_dec;
    logic       w_step;
    logic [5:0] w_max;
    logic [5:0] w_hour_cap;
    logic [5:0] w_min_cap;
    logic [5:0] w_sec_cap;

    assign w_mode = r_press[0];
    assign w_inc  = r_press[1];
    assign w_dec  = r_press[2];
    // Coincident inc+dec cancel; mode takes precedence over either.
    assign w_step = (w_inc ^ w_dec) & ~w_mode;
    assign w_max  = (r_state == StEditHour) ? 6'd23 : 6'd59;

    // Out-of-range captures restart the field at zero.
    assign w_hour_cap = (io_bus.hour_in > 5'd23) ? 6'd0 : {1'b0, io_bus.hour_in};
    assign w_min_cap  = (io_bus.min_in > 6'd59) ? 6'd0 : io_bus.min_in;
    assign w_sec_cap  = (io_bus.sec_in > 6'd59) ? 6'd0 : io_bus.sec_in;

    always_comb begin
        w_state_next     = r_state;
        w_edit_val_next  = r_edit_val;
        w_data_next      = r_data;
        w_load_hour_next = 1'b0;
        w_load_min_next  = 1'b0;
        w_load_sec_next  = 1'b0;
        w_blink_next     = r_blink;

        if (r_state != StRun && io_bus.tick_1hz) begin
            w_blink_next = ~r_blink;
        end

        if (w_mode) begin
            // Every field change restarts the blink phase.
            w_blink_next = 1'b0;
            unique case (r_state)
                StRun: begin
                    w_edit_val_next = w_hour_cap;
                    w_state_next    = StEditHour;
                end
                StEditHour: begin
                    w_data_next      = r_edit_val;
                    w_load_hour_next = 1'b1;
                    w_edit_val_next  = w_min_cap;
                    w_state_next     = StEditMin;
                end
                StEditMin: begin
                    w_data_next     = r_edit_val;
                    w_load_min_next = 1'b1;
                    w_edit_val_next = w_sec_cap;
                    w_state_next    = StEditSec;
                end
                StEditSec: begin
                    w_data_next     = r_edit_val;
                    w_load_sec_next = 1'b1;
                    w_state_next    = StRun;
                end
            endcase
        end else if (w_step && r_state != StRun) begin
            if (w_inc) begin
                w_edit_val_next = (r_edit_val >= w_max) ? 6'd0 : r_edit_val + 6'd1;
            end else begin
                w_edit_val_next = (r_edit_val == 6'd0 || r_edit_val > w_max) ?
                                  w_max : r_edit_val - 6'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StRun;
            r_edit_val  <= '0;
            r_data      <= '0;
            r_load_hour <= 1'b0;
            r_load_min  <= 1'b0;
            r_load_sec  <= 1'b0;
            r_blink     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_edit_val  <= w_edit_val_next;
            r_data      <= w_data_next;
            r_load_hour <= w_load_hour_next;
            r_load_min  <= w_load_min_next;
            r_load_sec  <= w_load_sec_next;
            r_blink     <= w_blink_next;
        end
    end

    assign io_bus.data       = r_data;
    assign io_bus.load_hour  = r_load_hour;
    assign io_bus.load_min   = r_load_min;
    assign io_bus.load_sec   = r_load_sec;
    // load_sec is issued on the edge that returns to RUN, so this also covers that cycle.
    assign io_bus.run_en     = (r_state == StRun);
    assign io_bus.edit_field = r_state;
    assign io_bus.blink      = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: randomized and directed stimulus for time_set_ctrl. A behavioural model
// predicts each load strobe and pushes it into a scoreboard queue; a monitor process pops and
// compares whenever the controller presents a load.
module tb_time_set_ctrl;

    localparam int DB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];          // {field(2), value(6)}
    logic [5:0] sb_last = 6'd0;    // data value expected while no strobe is high

    // Behavioural model of the editor.
    int m_state = 0;               // 0 run, 1 hour, 2 minute, 3 second
    int m_val   = 0;
    int m_blink = 0;
    int hour_v  = 0;
    int min_v   = 0;
    int sec_v   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int mx);
        return (v > mx) ? 0 : v;
    endfunction

    task automatic model_press(input bit m, input bit i, input bit d);
        int mx;
        if (m) begin
            case (m_state)
                0: begin m_val = clampv(hour_v, 23); m_state = 1; end
                1: begin
                    exp_q.push_back({2'd1, 6'(m_val)});
                    m_val = clampv(min_v, 59); m_state = 2;
                end
                2: begin
                    exp_q.push_back({2'd2, 6'(m_val)});
                    m_val = clampv(sec_v, 59); m_state = 3;
                end
                default: begin
                    exp_q.push_back({2'd3, 6'(m_val)});
                    m_state = 0;
                end
            endcase
            m_blink = 0;
        end else if (i != d && m_state != 0) begin
            mx = (m_state == 1) ? 23 : 59;
            if (i) m_val = (m_val == mx) ? 0 : m_val + 1;
            else   m_val = (m_val == 0) ? mx : m_val - 1;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour_v = h; min_v = m; sec_v = s;
        bus.hour_in = 5'(h);
        bus.min_in  = 6'(m);
        bus.sec_in  = 6'(s);
    endtask

    task automatic drive_btn(input bit m, input bit i, input bit d);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        bus.btn_dec  = d;
    endtask

    task automatic chk_status();
        chk("edit_field", int'(bus.edit_field), m_state);
        chk("run_en", int'(bus.run_en), (m_state == 0) ? 1 : 0);
        chk("blink", int'(bus.blink), m_blink);
    endtask

    // Hold the buttons long enough for one debounced press, release, then check status.
    task automatic press(input bit m, input bit i, input bit d, input int hold);
        model_press(m, i, d);
        @(negedge clk);
        drive_btn(m, i, d);
        repeat (hold) @(negedge clk);
        drive_btn(0, 0, 0);
        repeat (5) @(negedge clk);
        chk_status();
    endtask

    task automatic tick();
        @(negedge clk);
        bus.tick_1hz = 1'b1;
        @(negedge clk);
        bus.tick_1hz = 1'b0;
        if (m_state != 0) m_blink ^= 1;
        chk("blink_tick", int'(bus.blink), m_blink);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_data", int'(bus.data), 0);
        chk("rst_loads", int'({bus.load_hour, bus.load_min, bus.load_sec}), 0);
        chk("rst_run_en", int'(bus.run_en), 1);
        chk("rst_edit_field", int'(bus.edit_field), 0);
        chk("rst_blink", int'(bus.blink), 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        exp_q.delete();
        m_state = 0; m_val = 0; m_blink = 0; sb_last = 6'd0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Scoreboard monitor.
    logic [2:0] mon_ld;
    logic [7:0] mon_e;
    int         mon_f;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon_ld = {bus.load_hour, bus.load_min, bus.load_sec};
                if (mon_ld != 3'b000) begin
                    chk("load_onehot", $countones(mon_ld), 1);
                    mon_f = mon_ld[2] ? 1 : (mon_ld[1] ? 2 : 3);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_load: got field %0d data %0d, required none",
                                 mon_f, bus.data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("load_field", mon_f, int'(mon_e[7:6]));
                        chk("load_data", int'(bus.data), int'(mon_e[5:0]));
                        sb_last = mon_e[5:0];
                    end
                end else begin
                    chk("data_hold", int'(bus.data), int'(sb_last));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        drive_btn(0, 0, 0);
        bus.tick_1hz = 1'b0;
        set_time(5, 30, 12);

        // Reset state.
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Press latency: mode high before edge 0, field changes on edge DB+3.
        model_press(1, 0, 0);
        @(negedge clk);
        drive_btn(1, 0, 0);
        for (int e = 0; e <= DB + 3; e++) begin
            @(posedge clk);
            #1 chk("press_latency", int'(bus.edit_field), (e >= DB + 3) ? 1 : 0);
        end
        repeat (3) @(negedge clk);
        drive_btn(0, 0, 0);
        repeat (5) @(negedge clk);
        chk_status();

        // Glitch of 10 cycles is ignored; 20 cycles gives one inc.
        @(negedge clk);
        drive_btn(0, 1, 0);
        repeat (10) @(negedge clk);
        drive_btn(0, 0, 0);
        repeat (5) @(negedge clk);
        press(0, 1, 0, 20);
        press(0, 1, 0, DB + 6);
        press(0, 1, 0, DB + 6);          // hour 8
        press(1, 0, 0, DB + 6);          // load_hour 8
        press(0, 0, 1, DB + 6);          // minute 29
        press(1, 0, 0, DB + 6);          // load_min 29
        press(1, 0, 0, DB + 6);          // load_sec 12, RUN

        // Blink in EDIT_HOUR, cleared by field change.
        press(1, 0, 0, DB + 6);
        tick(); repeat (3) @(negedge clk);
        tick(); repeat (3) @(negedge clk);
        tick();
        press(1, 0, 0, DB + 6);          // load_hour 5, EDIT_MIN blink 0

        // Simultaneous presses in EDIT_MIN.
        press(0, 1, 1, DB + 6);          // unchanged
        press(1, 1, 0, DB + 6);          // load_min 30 (pre-inc)
        press(1, 0, 0, DB + 6);          // load_sec 12

        // Wrap and clamp.
        set_time(23, 45, 0);
        press(1, 0, 0, DB + 6);
        press(0, 1, 0, DB + 6);          // 23 -> 0
        press(1, 0, 0, DB + 6);          // load_hour 0
        press(1, 0, 0, DB + 6);          // load_min 45
        press(0, 0, 1, DB + 6);          // 0 -> 59
        press(1, 0, 0, DB + 6);          // load_sec 59
        set_time(31, 60, 63);
        for (int n = 0; n < 4; n++) press(1, 0, 0, DB + 6);  // loads 0, 0, 0

        // Reset mid-edit abandons the edit.
        set_time(7, 8, 9);
        press(1, 0, 0, DB + 6);
        press(1, 0, 0, DB + 6);          // load_hour 7, EDIT_MIN
        mid_reset();
        repeat (10) @(negedge clk);
        chk_status();
        press(0, 1, 0, DB + 6);          // ignored in RUN

        // Randomized presses.
        for (int n = 0; n < 40; n++) begin
            set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            k = $urandom_range(0, 5);
            case (k)
                0: press(1, 0, 0, DB + 6);
                1: press(0, 1, 0, DB + 6);
                2: press(0, 0, 1, DB + 6);
                3: press(0, 1, 1, DB + 6);
                4: press(1, 1, 0, DB + 6);
                default: press(1, 0, 1, DB + 6);
            endcase
            if ($urandom_range(0, 1) == 1) tick();
        end
        while (m_state != 0) press(1, 0, 0, DB + 6);

        repeat (10) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable-high clk cycles required to accept a button press.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 btn_mode, btn_inc, btn_dec  input  1 each  raw asynchronous push-buttons, active-high.
REQ-005 tick_1hz  input  1  one-clk-wide 1 Hz strobe, synchronous to clk.
REQ-006 hour_in  input  5  current hour, 0-23; sec_in, min_in  input  6 each  current second/minute, 0-59.
REQ-007 data  output  6  value to load; hour values zero-extended (data[5]=0).
REQ-008 load_hour, load_min, load_sec  output  1 each  one-cycle load strobes for the hour/minute/second counters.
REQ-009 run_en  output  1  counter enable; 1 = clock running.
REQ-010 edit_field  output  2  0=run, 1=hour, 2=minute, 3=second.
REQ-011 blink  output  1  display blink phase for the field being edited.

Function
REQ-012 Each button passes through a 2-flop synchronizer, then a debounce counter that resets on any synchronized low sample.
REQ-013 Debounced level rises when the counter reaches DEBOUNCE_CYCLES; a one-cycle internal press pulse follows on the next edge; the next press requires the debounced level to fall and rise again.
REQ-014 Press-pulse latency: raw input high from edge 0 and held stable gives a press pulse active during the cycle after edge DEBOUNCE_CYCLES+2; glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse.
REQ-015 FSM states: RUN, EDIT_HOUR, EDIT_MIN, EDIT_SEC; edit_field encodes the state per REQ-010.
REQ-016 RUN + mode press: capture hour_in into edit_val and enter EDIT_HOUR; inc/dec presses in RUN are ignored.
REQ-017 EDIT_HOUR + mode press: next cycle data=edit_val and load_hour=1 for exactly one cycle; capture min_in into edit_val; enter EDIT_MIN.
REQ-018 EDIT_MIN + mode press: data=edit_val and load_min=1 for one cycle; capture sec_in; enter EDIT_SEC.
REQ-019 EDIT_SEC + mode press: data=edit_val and load_sec=1 for one cycle; return to RUN.
REQ-020 At most one load strobe is high in any cycle; data holds its last value when no strobe is high.
REQ-021 inc press: edit_val+1, wrapping from max (23 hour, 59 min/sec) to 0; dec press: edit_val-1, wrapping from 0 to max.
REQ-022 Captured values above the field max are clamped to 0 at capture.
REQ-023 inc and dec pulses in the same cycle: both ignored; mode pulse coincident with inc/dec: mode acts, inc/dec dropped.
REQ-024 run_en=1 in RUN and in the cycle carrying load_sec; 0 in every other edit-state cycle.
REQ-025 blink=0 in RUN; toggles on each tick_1hz while in an edit state; cleared to 0 on every field change.
REQ-026 edit_val arithmetic is 6-bit unsigned; no output other than data reflects edit_val.

Reset
REQ-027 reset_n low asynchronously forces: state RUN, edit_val=0, data=0, all load strobes 0, run_en=1, edit_field=0, blink=0, synchronizers and debounce counters cleared.
REQ-028 Reset asserted mid-edit abandons the edit with no load strobe emitted; operation resumes in RUN after reset_n rises.

Verification
REQ-029 Debounce: btn_inc high 10 cycles then low, DEBOUNCE_CYCLES=16 -> no press; held 20 cycles -> exactly one press, pulse at the cycle given by REQ-014.
REQ-030 Full set: hour_in=5, min_in=30, sec_in=12; mode, inc x3, mode, dec, mode, mode -> load_hour with data=8, load_min with data=29, load_sec with data=12, back to RUN, run_en=1.
REQ-031 Wrap: EDIT_HOUR, edit_val=23, inc -> 0; EDIT_SEC, edit_val=0, dec -> 59; hour_in=31 captured -> edit_val=0.
REQ-032 Simultaneous: inc+dec same cycle in EDIT_MIN -> edit_val unchanged; mode+inc same cycle -> load_min with pre-inc value.
REQ-033 Reset mid-edit: enter EDIT_MIN, pulse reset_n low -> all outputs at REQ-027 values immediately, no load strobe before or after.
REQ-034 Blink: EDIT_HOUR with 3 tick_1hz pulses -> blink 0->1->0->1; mode press -> blink=0 in EDIT_MIN.
